// File: rtl/conv2_sched.sv
// conv2 window scheduler and result sequencer.
// Optional cycle counter: define CONV2_SCHED_PERF_EN.
module conv2_sched #(
  parameter int IN_W      = 12,
  parameter int K         = 5,
  parameter int CALC_LAT  = 4,
  parameter int OUT_W     = IN_W - K + 1,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pause,
  output logic                 busy,
  output logic                 done,
  output logic                 win_valid,
  output logic [3:0]           win_row,
  output logic [3:0]           win_col,
  input  logic                 calc_valid,
  input  logic [7:0]           calc_data,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 err,
  output logic [15:0]          cycle_cnt
);

  localparam int NWIN = OUT_W * OUT_W;
  localparam int CW   = ADDR_BITS + 1;

  typedef enum logic [1:0] {
    IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t        state, state_nx;
  logic          start_q;
  logic [3:0]    nr, nc;
  logic [3:0]    cur_r, cur_c;
  logic [3:0]    outstanding;
  logic [CW-1:0] wr_cnt;
  logic          start_acc, issue, last;
  logic          res_ok, dec, drained;

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);

  // issue / accept decisions and next-state
  always_comb begin
    state_nx  = state;
    start_acc = (state == IDLE) && start && !start_q;
    cur_r     = (state == IDLE) ? 4'd0 : nr;
    cur_c     = (state == IDLE) ? 4'd0 : nc;
    issue     = !pause
              && (outstanding <= 4'(CALC_LAT))
              && (start_acc || state == ISSUE);
    last      = issue
              && cur_r == 4'(OUT_W - 1)
              && cur_c == 4'(OUT_W - 1);
    dec       = calc_valid && outstanding != 4'd0;
    res_ok    = dec && (state != IDLE)
              && wr_cnt != CW'(NWIN);
    drained   = wr_cnt == CW'(NWIN)
              && outstanding == 4'd0;
    case (state)
      IDLE:  if (start_acc)
               state_nx = last ? DRAIN : ISSUE;
      ISSUE: if (last) state_nx = DRAIN;
      DRAIN: if (drained) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state register and start edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start;
    end
  end

  // raster-scan window issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      nr        <= '0;
      nc        <= '0;
    end else if (issue) begin
      win_valid <= 1'b1;
      win_row   <= cur_r;
      win_col   <= cur_c;
      if (cur_c == 4'(OUT_W - 1)) begin
        nc <= '0;
        nr <= cur_r + 4'd1;
      end else begin
        nc <= cur_c + 4'd1;
        nr <= cur_r;
      end
    end else begin
      win_valid <= 1'b0;
      if (state == IDLE) begin
        nr <= '0;
        nc <= '0;
      end
    end
  end

  // in-flight window count across the calculator
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      outstanding <= '0;
    else if (start_acc)
      outstanding <= '0;
    else
      outstanding <= outstanding
                   + {3'd0, win_valid}
                   - {3'd0, dec};
  end

  // result capture, write strobe and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      wr_en <= res_ok;
      if (start_acc)
        wr_cnt <= '0;
      if (res_ok) begin
        wr_data <= calc_data;
        wr_addr <= wr_cnt[ADDR_BITS-1:0];
        wr_cnt  <= wr_cnt + CW'(1);
      end
      if (calc_valid && !res_ok)
        err <= 1'b1;
    end
  end

`ifdef CONV2_SCHED_PERF_EN
  logic [15:0] perf_q;

  // busy-cycle counter, start cycle included
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perf_q <= '0;
    else if (start_acc)
      perf_q <= 16'd1;
    else if (busy && perf_q != 16'hFFFF)
      perf_q <= perf_q + 16'd1;
  end

  assign cycle_cnt = perf_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_conv2_sched.sv
// Directed bench for conv2_sched.
// Model calculator: 4-cycle delay, data = row*8+col.
module tb_conv2_sched;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic       busy, done, win_valid;
  logic [3:0] win_row, win_col;
  logic       calc_valid;
  logic [7:0] calc_data;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       err;
  logic [15:0] cycle_cnt;

  logic [3:0] pv = '0;
  logic [7:0] pd [4];
  logic       inj = 1'b0;
  logic [7:0] inj_d = 8'hAA;

  int tests = 0;
  int fails = 0;

`ifdef CONV2_SCHED_PERF_EN
  localparam logic [15:0] EXP_CC = 16'd70;
`else
  localparam logic [15:0] EXP_CC = 16'd0;
`endif

  conv2_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .pause(pause), .busy(busy), .done(done),
    .win_valid(win_valid), .win_row(win_row),
    .win_col(win_col), .calc_valid(calc_valid),
    .calc_data(calc_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pv    <= {pv[2:0], win_valid};
    pd[0] <= 8'(win_row) * 8'd8 + 8'(win_col);
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end

  assign calc_valid = pv[3] | inj;
  assign calc_data  = inj ? inj_d : pd[3];

  task automatic mon(
    input  int maxc, input int p_lo,
    input  int p_hi, input int s_hi,
    input  int inj_c,
    output int done_c, output int nwin,
    output int nwr, output int bad,
    output int max_o, output int extra,
    output logic [7:0] w47,
    output logic [7:0] w48
  );
    done_c = 0; nwin = 0; nwr = 0;
    bad = 0; max_o = 0; extra = 0;
    w47 = '0; w48 = '0;
    start = 1'b1;
    pause = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= maxc; c++) begin
      start = (c < s_hi);
      pause = (c >= p_lo && c <= p_hi);
      inj   = (c == inj_c);
      if (win_valid) begin
        if (done_c != 0 || nwin >= 64) begin
          extra++;
        end else begin
          if (win_row !== 4'(nwin / 8) ||
              win_col !== 4'(nwin % 8))
            bad++;
          if (nwin == 47) w47 = {win_row, win_col};
          if (nwin == 48) w48 = {win_row, win_col};
          nwin++;
        end
      end
      if (wr_en) begin
        if (wr_addr !== 6'(nwr) ||
            wr_data !== 8'(nwr))
          bad++;
        nwr++;
      end
      if (int'(dut.outstanding) > max_o)
        max_o = int'(dut.outstanding);
      if (done && done_c == 0) done_c = c;
      @(posedge clk); #1;
    end
    start = 1'b0;
    pause = 1'b0;
    inj   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL rst_done got %b want 0", done);
    end
    tests++;
    if (win_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_wv got %b want 0", win_valid);
    end
    tests++;
    if ({win_row, win_col} !== 8'h00) begin
      fails++;
      $display("FAIL rst_rc got %h want 00",
               {win_row, win_col});
    end
    tests++;
    if (wr_en !== 1'b0) begin
      fails++;
      $display("FAIL rst_wren got %b want 0", wr_en);
    end
    tests++;
    if (wr_addr !== 6'd0 || wr_data !== 8'd0) begin
      fails++;
      $display("FAIL rst_wr got %h/%h want 0/0",
               wr_addr, wr_data);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL rst_err got %b want 0", err);
    end
    tests++;
    if (cycle_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rst_cc got %0d want 0", cycle_cnt);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    int d, nw, nr, b, mo, ex;
    logic [7:0] a47, a48;
    mon(72, 1000, 0, 1, 0,
        d, nw, nr, b, mo, ex, a47, a48);
    tests++;
    if (d !== 70) begin
      fails++;
      $display("FAIL frame_done got %0d want 70", d);
    end
    tests++;
    if (nw !== 64 || nr !== 64) begin
      fails++;
      $display("FAIL frame_cnt got %0d/%0d want 64/64",
               nw, nr);
    end
    tests++;
    if (b !== 0) begin
      fails++;
      $display("FAIL frame_order got %0d bad want 0", b);
    end
    tests++;
    if (a47 !== 8'h57 || a48 !== 8'h60) begin
      fails++;
      $display("FAIL row_wrap got %h,%h want 57,60",
               a47, a48);
    end
    tests++;
    if (mo > 5 || mo == 0) begin
      fails++;
      $display("FAIL outstanding got %0d want 1..5", mo);
    end
    tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_end err/busy got %b/%b want 0/0",
               err, busy);
    end
    tests++;
    if (cycle_cnt !== EXP_CC) begin
      fails++;
      $display("FAIL frame_cc got %0d want %0d",
               cycle_cnt, EXP_CC);
    end
  endtask

  task automatic test_pause();
    int d, nw, nr, b, mo, ex;
    logic [7:0] a47, a48;
    mon(78, 10, 14, 1, 0,
        d, nw, nr, b, mo, ex, a47, a48);
    tests++;
    if (d !== 75) begin
      fails++;
      $display("FAIL pause_done got %0d want 75", d);
    end
    tests++;
    if (b !== 0 || nw !== 64 || nr !== 64) begin
      fails++;
      $display("FAIL pause_seq got bad=%0d w=%0d r=%0d want 0/64/64",
               b, nw, nr);
    end
  endtask

  task automatic test_hold_start();
    int d, nw, nr, b, mo, ex;
    logic [7:0] a47, a48;
    mon(90, 1000, 0, 80, 0,
        d, nw, nr, b, mo, ex, a47, a48);
    tests++;
    if (d !== 70 || nr !== 64) begin
      fails++;
      $display("FAIL hold_frame got done=%0d wr=%0d want 70/64",
               d, nr);
    end
    tests++;
    if (ex !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL hold_restart got extra=%0d busy=%b want 0/0",
               ex, busy);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, nw, nr, b, mo, ex;
    logic [7:0] a47, a48;
    mon(70, 1000, 0, 1, 0,
        d1, nw, nr, b, mo, ex, a47, a48);
    mon(72, 1000, 0, 1, 0,
        d2, nw, nr, b, mo, ex, a47, a48);
    tests++;
    if (d1 !== 70 || d2 !== 70) begin
      fails++;
      $display("FAIL b2b_done got %0d,%0d want 70,70",
               d1, d2);
    end
    tests++;
    if (b !== 0 || nr !== 64) begin
      fails++;
      $display("FAIL b2b_seq got bad=%0d wr=%0d want 0/64",
               b, nr);
    end
  endtask

  task automatic test_inject();
    int d, nw, nr, b, mo, ex;
    logic [7:0] a47, a48;
    mon(72, 1000, 0, 1, 1,
        d, nw, nr, b, mo, ex, a47, a48);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL inj_err got %b want 1", err);
    end
    tests++;
    if (d !== 70 || nr !== 64 || b !== 0) begin
      fails++;
      $display("FAIL inj_frame got d=%0d wr=%0d bad=%0d want 70/64/0",
               d, nr, b);
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL inj_sticky got %b want 1", err);
    end
  endtask

  task automatic test_rst_mid();
    int d, nw, nr, b, mo, ex, nwe;
    logic [7:0] a47, a48;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mon(29, 1000, 0, 1, 0,
        d, nw, nr, b, mo, ex, a47, a48);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, win_valid, wr_en, err} !== 5'b0 ||
        {win_row, win_col} !== 8'h00 ||
        wr_addr !== 6'd0 || wr_data !== 8'd0 ||
        cycle_cnt !== 16'd0) begin
      fails++;
      $display("FAIL rst_mid got %b %h %h %h want all 0",
               {busy, done, win_valid, wr_en, err},
               {win_row, win_col}, wr_addr, wr_data);
    end
    rst = 1'b0;
    nwe = 0;
    for (int c = 0; c < 10; c++) begin
      if (wr_en) nwe++;
      @(posedge clk); #1;
    end
    tests++;
    if (nwe !== 0 || err !== 1'b1) begin
      fails++;
      $display("FAIL rst_stray got wr=%0d err=%b want 0/1",
               nwe, err);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_pause();
    test_hold_start();
    test_back_to_back();
    test_inject();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/conv2_sched.md
# conv2_sched

Window scheduler and result sequencer for the conv2 MAC pipeline. On `start` it raster-scans every valid 5x5 window position of the 3-channel pooled feature map and issues one window per cycle to the conv2 calculator. It tracks in-flight windows across the calculator's fixed 4-cycle latency and writes each 8-bit result to the conv2 output feature RAM. It then signals completion to the layer controller.

## Interface
Parameters:
- `IN_W`, 12: input feature-map width = height.
- `K`, 5: kernel size.
- `CALC_LAT`, 4: calculator latency from `in_valid` to `out_valid`, in cycles.
- `OUT_W`, `IN_W-K+1` (8): output map width = height.
- `ADDR_BITS`, 6: output RAM address width; must satisfy 2^ADDR_BITS ≥ OUT_W².

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to process one feature map.
- `pause` in 1: feature buffer not ready; suppresses new window issue.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when all results have been written.
- `win_valid` out 1: drives calculator `in_valid`; window at (`win_row`,`win_col`) is presented this cycle.
- `win_row` out 4: window top-left row, 0..OUT_W-1.
- `win_col` out 4: window top-left column, 0..OUT_W-1.
- `calc_valid` in 1: calculator `out_valid`.
- `calc_data` in 8: calculator `data_out`.
- `wr_en` out 1: output RAM write strobe.
- `wr_addr` out ADDR_BITS: result index, row*OUT_W+col.
- `wr_data` out 8: registered `calc_data`.
- `err` out 1: sticky protocol error.
- `cycle_cnt` out 16: performance counter (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when `start`=1, clear all counters and go to ISSUE. While not in IDLE, `start` is ignored.
- ISSUE:
  - When `pause`=0, assert `win_valid` with the current (row,col), then advance: col+1; at col=OUT_W-1, col←0 and row+1.
  - When `pause`=1, `win_valid`=0 and coordinates hold.
  - After issuing (OUT_W-1,OUT_W-1), go to DRAIN.
- DRAIN: no issue. When `wr_cnt`=OUT_W² and `outstanding`=0, go to DONE.
- DONE: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- `outstanding` counter, 4 bits:
  - +1 on `win_valid`, -1 on `calc_valid`; both in the same cycle leaves it unchanged.
  - Never exceeds CALC_LAT+1.
- Result path:
  - `calc_valid` registers `calc_data` into `wr_data`, and asserts `wr_en` the next cycle with `wr_addr`=`wr_cnt`.
  - `wr_cnt` increments after each write and is not wrapped.
- `err` is set and held until `rst` when any of these occurs:
  - `calc_valid`=1 while `outstanding`=0;
  - `calc_valid`=1 in IDLE;
  - a write attempted with `wr_cnt`=OUT_W².
- An illegal result is dropped: `err` is set but no `wr_en` is generated.
- `rst` asserted at any point: immediate return to IDLE and all outputs go to reset values. In-flight calculator results arriving after reset flag `err`.

## Timing
- Reset values: `busy`=0, `done`=0, `win_valid`=0, `win_row`=0, `win_col`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `err`=0, `cycle_cnt`=0.
- `start` sampled at edge 0. Then `busy`=1 and `win_valid`=1 for window (0,0) from cycle 1.
- No pause: windows issue in cycles 1..64; `calc_valid` in 5..68; `wr_en` in 6..69; `done` in cycle 70.
- Each `pause` cycle during ISSUE delays `done` by exactly one cycle.
- `pause` during DRAIN has no effect.
- `win_valid`, `win_row` and `win_col` are registered outputs; `done` is a registered output.
- A new `start` is accepted no earlier than the cycle after `done`. Back-to-back start gives 71-cycle spacing.

## Configuration
- `CONV2_SCHED_PERF_EN` defined: `cycle_cnt` clears on an accepted `start`, increments every cycle while `busy`=1, saturates at 0xFFFF, and holds its value after `done` until the next `start`.
- Not defined: `cycle_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Reset, then `start` with a model calculator (4-cycle delay, data=index&0xFF) -> 64 writes with `wr_addr` 0..63 and `wr_data`=addr; `done` in cycle 70; `err`=0; `cycle_cnt`=70 with PERF.
- `pause` high for cycles 10..14 -> windows stay in raster order with no gaps in `wr_addr`; `done` in cycle 75.
- `start` held high for 80 cycles -> exactly one frame processed; next frame starts only after `start` is deasserted and reasserted.
- `rst` pulsed at cycle 30 -> all outputs at reset values next cycle; stray `calc_valid` afterward sets `err`=1 with no `wr_en`.
- Injected extra `calc_valid` while `outstanding`=0 -> `err`=1 sticky, write suppressed, frame completes normally.
- Windows issued (5,7) then (6,0) -> correct row wrap on `win_row`/`win_col`; `outstanding` never exceeds 5.
